if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage for the 5-stage MIPS core; sits directly upstream of the decode block.
- Owns the PC register and issues fetches to the instruction-memory port, which has variable latency and allows one request outstanding.
- Delivers {valid, pc, inst} through a registered IF/ID boundary with a 1-entry skid buffer.
- Handles the MIPS branch delay slot, pipeline flush/redirect and misaligned-PC detection.

Parameters:
- RESET_PC, 32'hBFC00000, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address; equals pc while inst_req=1.
- inst_ready  in  1  memory accepts request this cycle (handshake inst_req & inst_ready).
- inst_rvalid  in  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- inst_rdata  in  32  instruction word.
- id_stall  in  1  decode cannot take a new instruction; holds id_* outputs.
- br_taken  in  1  one-cycle pulse: branch leaving decode is taken. Legal only when id_valid=1 and id_stall=0.
- br_target  in  32  branch target, valid with br_taken.
- flush  in  1  exception/eret redirect; discards all fetch state.
- flush_pc  in  32  new PC, valid with flush.
- id_valid  out  1  id_pc/id_inst hold a live instruction.
- id_pc  out  32  PC of the delivered instruction.
- id_inst  out  32  instruction word forwarded to decode.
- id_adel  out  1  delivered entry is an address-error (PC[1:0]!=0); id_inst=0 in that case.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; state=REQ; id_valid=0, id_pc=0, id_inst=0, id_adel=0.
  - skid empty; br_pend=0; discard=0.
  - inst_req=0 during the reset cycle.
  - Reset mid-transaction: a later inst_rvalid for the pre-reset request is ignored only if it arrives while discard=1. The memory side is reset on the same rst, so no stale response is expected.
- States:
  - REQ: inst_req=1 iff skid empty and pc[1:0]==0.
    - Handshake → WAIT.
    - pc[1:0]!=0 → no request. Synthesize an entry {pc, inst=0, adel=1} and deliver it this cycle (same delivery rules as a response); stay REQ.
  - WAIT: inst_req=0. On inst_rvalid:
    - discard=1 → drop the data, clear discard, → REQ.
    - discard=0 → deliver {pc, inst_rdata, adel=0}, → REQ.
- Delivery:
  - If id_valid=0 or id_stall=0: load id_* registers (id_valid=1) on the next edge.
  - Else: write the skid.
  - Each delivery advances pc: pc ← (br_pend | br_taken) ? (br_taken ? br_target : tgt_reg) : pc+4. br_pend clears.
- Draining the skid:
  - When the skid is full and id_stall=0, the skid moves to id_*.
  - REQ does not issue while the skid is full, so occupancy is never above 1.
- id_valid clears on an edge where id_stall=0 and there is no new delivery or skid transfer.
- Delay slot:
  - br_taken with no delivery in the same cycle → tgt_reg=br_target, br_pend=1. The next delivered instruction (the delay slot, PC = branch+4) is kept, and the PC after it is the target.
  - br_taken in the same cycle as the delay-slot delivery → pc=br_target directly.
- Flush (highest priority, overrides br_taken/delivery):
  - pc=flush_pc; id_valid=0; skid empty; br_pend=0.
  - If in WAIT with the response not arriving this cycle, set discard=1 and stay WAIT. Otherwise go to REQ.
  - flush while discard=1 already set: discard stays 1.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (32'hFFFFFFFC → 0).
- Ordering: instructions reach id_* in strict program order. No instruction is duplicated or lost except by flush.

Test Plan:
- Reset, then 1-cycle memory (inst_ready=1, rvalid 1 cycle after accept) → inst_addr BFC00000, BFC00004, BFC00008… Each id_inst matches memory, id_pc in order, one instruction every 2 cycles.
- id_stall=1 for 5 cycles while a response arrives → skid holds it and inst_req=0. id_* stays frozen. After release, the buffered PC appears next with no loss or duplication.
- Branch at BFC00010 leaves decode with br_taken, target BFC00100 → next delivered PCs are BFC00014 (delay slot), then BFC00100. Repeat with rvalid coinciding with the br_taken cycle → same sequence.
- flush with flush_pc=BFC00380 while in WAIT, rvalid 3 cycles later with data DEADBEEF → DEADBEEF never appears on id_inst. Next inst_addr is BFC00380, and id_valid=0 until it returns.
- flush_pc=BFC00382 → inst_req stays 0. id_valid=1, id_adel=1, id_pc=BFC00382, id_inst=0.
- Assert rst during WAIT → the next cycle shows id_valid=0 and pc=RESET_PC, and a fresh request goes to BFC00000.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage and the instruction memory.
// One request outstanding; exactly one rvalid per accepted request.
interface if_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ready,
    input  inst_rvalid,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ready,
    output inst_rvalid,
    output inst_rdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC ownership, single-outstanding fetch,
// registered IF/ID boundary with 1-entry skid, delay-slot and flush handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        mem,
  input  logic              id_stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  output logic              id_adel
);

  localparam int unsigned XLEN = 32;

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]      state, state_nxt;
  logic            discard, discard_nxt;
  logic [XLEN-1:0] pc, pc_adv, tgt_reg;
  logic            br_pend;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc, skid_inst;
  logic            skid_adel;

  logic            req;
  logic            deliver;
  logic [XLEN-1:0] dlv_inst;
  logic            dlv_adel;

  assign pc_adv        = pc + XLEN'(4);
  assign mem.inst_req  = req;
  assign mem.inst_addr = pc;

  // Next state, fetch request and delivery decode
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    req         = 1'b0;
    deliver     = 1'b0;
    dlv_inst    = '0;
    dlv_adel    = 1'b0;
    case (state)
      S_REQ: begin
        if (!skid_valid) begin
          if (pc[1:0] == 2'b00) begin
            req = !rst && !flush;
          end else begin
            deliver  = !flush;
            dlv_adel = 1'b1;
          end
        end
        if (req && mem.inst_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem.inst_rvalid) begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
          if (!discard) begin
            deliver  = !flush;
            dlv_inst = mem.inst_rdata;
          end
        end
      end
      default: state_nxt = S_REQ;
    endcase
    // A flush with the response still in flight must swallow that response
    if (flush && state == S_WAIT && !mem.inst_rvalid) discard_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  // PC, branch-pending, skid and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      tgt_reg    <= '0;
      br_pend    <= 1'b0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      skid_adel  <= 1'b0;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_inst    <= '0;
      id_adel    <= 1'b0;
    end else if (flush) begin
      pc         <= flush_pc;
      br_pend    <= 1'b0;
      skid_valid <= 1'b0;
      id_valid   <= 1'b0;
    end else begin
      if (skid_valid && !id_stall) begin
        id_valid   <= 1'b1;
        id_pc      <= skid_pc;
        id_inst    <= skid_inst;
        id_adel    <= skid_adel;
        skid_valid <= 1'b0;
      end else if (deliver) begin
        if (!id_valid || !id_stall) begin
          id_valid <= 1'b1;
          id_pc    <= pc;
          id_inst  <= dlv_inst;
          id_adel  <= dlv_adel;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= pc;
          skid_inst  <= dlv_inst;
          skid_adel  <= dlv_adel;
        end
      end else if (!id_stall) begin
        id_valid <= 1'b0;
      end

      // A full skid already holds the delay slot, so a branch then redirects at once
      if (deliver) begin
        pc      <= br_taken ? br_target : (br_pend ? tgt_reg : pc_adv);
        br_pend <= 1'b0;
      end else if (br_taken && skid_valid) begin
        pc <= br_target;
      end else if (br_taken) begin
        tgt_reg <= br_target;
        br_pend <= 1'b1;
      end
    end
  end

endmodule
